// File: rtl/inv_key_schedule_if.sv
// Handshake and key bus between the reverse key scheduler and its consumer.
// The master drives start/key_last/key_ready; the slave (the scheduler) drives the rest.
interface inv_key_schedule_if;
  logic         start;
  logic [127:0] key_last;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         busy;
  logic         done;

  modport master (
    output start, key_last, key_ready,
    input  round_key, round_idx, key_valid, busy, done
  );

  modport slave (
    input  start, key_last, key_ready,
    output round_key, round_idx, key_valid, busy, done
  );
endinterface

// File: rtl/inv_key_schedule.sv
// AES-128 round-key generator running the expansion backwards from the round-10 key,
// emitting keys 10..0 one per accepted handshake.
module inv_key_schedule (
  input logic               clk,
  input logic               rst,
  inv_key_schedule_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  // Forward S-box: inverting the expansion still needs SubWord in the forward direction.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  logic [0:0]   state_r;
  logic [127:0] key_r;
  logic [3:0]   round_r;
  logic         done_r;

  logic [31:0]  w0_s, w1_s, w2_s, w3_s;
  logic [31:0]  w0_prev_s, w1_prev_s, w2_prev_s, w3_prev_s;
  logic [127:0] prev_key_s;
  logic         handshake_s;

  // One backward expansion step: w3' must be formed first since it feeds SubWord.
  always_comb begin
    w0_s       = key_r[127:96];
    w1_s       = key_r[95:64];
    w2_s       = key_r[63:32];
    w3_s       = key_r[31:0];
    w3_prev_s  = w3_s ^ w2_s;
    w2_prev_s  = w2_s ^ w1_s;
    w1_prev_s  = w1_s ^ w0_s;
    w0_prev_s  = w0_s ^ sub_word({w3_prev_s[23:0], w3_prev_s[31:24]}) ^ {rcon(round_r), 24'h000000};
    prev_key_s = {w0_prev_s, w1_prev_s, w2_prev_s, w3_prev_s};
  end

  assign handshake_s = (state_r == ST_EMIT) && bus.key_ready;

  // Sequencer: load on start in IDLE, step back one round per accepted key.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      key_r   <= 128'h0;
      round_r <= 4'd0;
      done_r  <= 1'b0;
    end else begin
      done_r <= handshake_s && (round_r == 4'd0);
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            key_r   <= bus.key_last;
            round_r <= 4'd10;
            state_r <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (bus.key_ready) begin
            if (round_r != 4'd0) begin
              key_r   <= prev_key_s;
              round_r <= round_r - 4'd1;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign bus.round_key = key_r;
  assign bus.round_idx = round_r;
  assign bus.key_valid = (state_r == ST_EMIT);
  assign bus.busy      = (state_r == ST_EMIT);
  assign bus.done      = done_r;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Self-checking bench for inv_key_schedule: hand-computed FIPS-197 vectors plus a
// word-wise inverse-expansion scoreboard and a forward-expansion round-trip check.
module tb_inv_key_schedule;

  logic clk = 1'b0;
  logic rst = 1'b1;
  inv_key_schedule_if bus();

  inv_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [2047:0] SBOX_BITS = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  typedef struct {
    logic [127:0] key_last;
    int           idx;
    logic [127:0] exp_key;
  } vec_t;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [127:0] exp_keys [0:10];
  logic [127:0] got_keys [0:10];

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX_BITS[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sb(r[31:24]), sb(r[23:16]), sb(r[15:8]), sb(r[7:0])};
  endfunction

  function automatic logic [7:0] rc(input int r);
    logic [7:0] c;
    c = 8'h01;
    for (int k = 1; k < r; k++) c = {c[6:0], 1'b0} ^ (c[7] ? 8'h1b : 8'h00);
    return c;
  endfunction

  // Standard forward expansion: round-0 key in, round-10 key out.
  function automatic logic [127:0] fwd(input logic [127:0] k0);
    logic [31:0] w [0:43];
    logic [31:0] t;
    {w[0], w[1], w[2], w[3]} = k0;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_rot(t) ^ {rc(i / 4), 24'h000000};
      w[i] = w[i-4] ^ t;
    end
    return {w[40], w[41], w[42], w[43]};
  endfunction

  // Scoreboard model: undo the expansion one word at a time, highest word first.
  task automatic inv_model(input logic [127:0] kl);
    logic [31:0] w [0:43];
    logic [31:0] t;
    {w[40], w[41], w[42], w[43]} = kl;
    for (int i = 43; i >= 4; i--) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_rot(t) ^ {rc(i / 4), 24'h000000};
      w[i-4] = w[i] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic [127:0] kl);
    bus.key_last = kl;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
  endtask

  // Consumes one sequence against exp_keys; optional stray start or reset at a given index.
  task automatic drain(input string tag, input int ready_pct, input int pulse_at, input int rst_at);
    int exp_idx;
    int cyc;
    bit ready;
    exp_idx = 10;
    cyc     = 0;
    while (exp_idx >= 0 && cyc < 400) begin
      check({tag, " ctl"}, 128'({bus.key_valid, bus.busy, bus.done}), 128'(3'b110));
      check({tag, " idx"}, 128'(bus.round_idx), 128'(exp_idx));
      check({tag, " key"}, bus.round_key, exp_keys[exp_idx]);
      got_keys[exp_idx] = bus.round_key;
      if (exp_idx == rst_at) begin
        rst = 1'b1; bus.start = 1'b1; bus.key_ready = 1'b1;
        step();
        rst = 1'b0; bus.start = 1'b0;
        check({tag, " rst ctl"}, 128'({bus.key_valid, bus.busy, bus.done}), 128'(3'b000));
        check({tag, " rst idx"}, 128'(bus.round_idx), 128'(4'd0));
        check({tag, " rst key"}, bus.round_key, 128'h0);
        step();
        check({tag, " post-rst ctl"}, 128'({bus.key_valid, bus.busy, bus.done}), 128'(3'b000));
        return;
      end
      ready         = (int'($urandom_range(99)) < ready_pct);
      bus.key_ready = ready;
      bus.start     = (exp_idx == pulse_at);
      if (exp_idx == pulse_at) bus.key_last = ~exp_keys[10];
      step();
      bus.start = 1'b0;
      if (ready) exp_idx--;
      cyc++;
    end
    if (exp_idx >= 0) begin
      chk_cnt++;
      $display("FAIL %s timeout: %0d keys still pending after %0d cycles", tag, exp_idx + 1, cyc);
    end else begin
      check({tag, " done ctl"}, 128'({bus.key_valid, bus.busy, bus.done}), 128'(3'b001));
    end
  endtask

  initial begin
    vec_t vecs [5];
    logic [127:0] last_kl;
    logic [127:0] k0;
    logic [127:0] kl;

    bus.start = 1'b0; bus.key_last = 128'h0; bus.key_ready = 1'b0;
    repeat (3) step();
    check("reset ctl", 128'({bus.key_valid, bus.busy, bus.done}), 128'(3'b000));
    check("reset idx", 128'(bus.round_idx), 128'(4'd0));
    check("reset key", bus.round_key, 128'h0);
    rst = 1'b0;
    step();
    check("idle ctl", 128'({bus.key_valid, bus.busy, bus.done}), 128'(3'b000));

    vecs[0] = '{FIPS_K10, 10, FIPS_K10};
    vecs[1] = '{FIPS_K10, 9,  128'hac7766f319fadc2128d12941575c006e};
    vecs[2] = '{FIPS_K10, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[3] = '{FIPS_K10, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[4] = '{128'h0,   10, 128'h0};
    last_kl = 128'hx;
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].key_last !== last_kl) begin
        inv_model(vecs[i].key_last);
        start_seq(vecs[i].key_last);
        drain("tbl", 100, -1, -1);
        step();
        check("done one cycle", 128'(bus.done), 128'(1'b0));
        last_kl = vecs[i].key_last;
      end
      check($sformatf("tbl vec%0d", i), got_keys[vecs[i].idx], vecs[i].exp_key);
    end

    inv_model(FIPS_K10);
    start_seq(FIPS_K10);
    drain("backpressure", 50, -1, -1);
    step();

    start_seq(FIPS_K10);
    drain("stray start", 100, 5, -1);
    step();

    start_seq(FIPS_K10);
    drain("mid rst", 100, -1, 6);
    start_seq(FIPS_K10);
    drain("restart", 100, -1, -1);
    step();

    start_seq(FIPS_K10);
    drain("b2b first", 100, -1, -1);
    bus.key_last = 128'h0;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    inv_model(128'h0);
    drain("b2b second", 100, -1, -1);
    step();

    for (int n = 0; n < 1000; n++) begin
      k0 = {$urandom, $urandom, $urandom, $urandom};
      kl = fwd(k0);
      inv_model(kl);
      start_seq(kl);
      drain("random", 80, -1, -1);
      check("random roundtrip", fwd(got_keys[0]), kl);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
